// File: rtl/intr_ctrl_if.sv
// Register port and CPU interrupt handshake between the CPU side and intr_ctrl.
interface intr_ctrl_if #(
   parameter int ID_W = 4
);
   logic            reg_we;
   logic [1:0]      reg_addr;
   logic [31:0]     reg_wdata;
   logic [31:0]     reg_rdata;
   logic            ack;
   logic            eret;
   logic            irq_out;
   logic [ID_W-1:0] irq_id;

   modport master (
      output reg_we, reg_addr, reg_wdata, ack, eret,
      input  reg_rdata, irq_out, irq_id
   );

   modport slave (
      input  reg_we, reg_addr, reg_wdata, ack, eret,
      output reg_rdata, irq_out, irq_id
   );
endinterface

// File: rtl/intr_ctrl.sv
// External interrupt controller: edge capture, masking, fixed priority, REQ/SERVICE handshake.
// Define INTC_TIMER_EN to add a periodic reload timer as lowest-priority source N_SRC.
//
// state   | meaning
// IDLE    | no request outstanding, waiting for an eligible source
// REQ     | irq_out high, waiting for CPU ack
// SERVICE | handler running, waiting for eret
module intr_ctrl #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   intr_ctrl_if.slave       bus
);
`ifdef INTC_TIMER_EN
   localparam int PW = N_SRC + 1;
`else
   localparam int PW = N_SRC;
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N_SRC-1:0]  sync1_q, sync2_q, sync3_q;
   logic [PW-1:0]     pend_q, pend_d, mask_q, mask_d;
   logic [PW-1:0]     elig, set_vec, ack_clr;
   logic              irq_out_q, irq_out_d;
   logic [ID_W-1:0]   irq_id_q, irq_id_d, win_id;
   logic              wr_pend, wr_mask, tmr_fire;
   logic              unused_wdata;

   assign wr_pend      = bus.reg_we && (bus.reg_addr == 2'd0);
   assign wr_mask      = bus.reg_we && (bus.reg_addr == 2'd1);
   assign elig         = pend_q & mask_q;
   assign unused_wdata = ^bus.reg_wdata[31:PW];

`ifdef INTC_TIMER_EN
   logic [31:0] reload_q, reload_d, count_q, count_d;

   always_comb begin
      reload_d = reload_q;
      count_d  = count_q;
      tmr_fire = 1'b0;
      if (bus.reg_we && (bus.reg_addr == 2'd3)) begin
         reload_d = bus.reg_wdata;
         count_d  = bus.reg_wdata;
      end else if (count_q != 32'd0) begin
         if (count_q == 32'd1) begin
            tmr_fire = 1'b1;
            count_d  = reload_q;
         end else begin
            count_d = count_q - 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reload_q <= '0;
         count_q  <= '0;
      end else begin
         reload_q <= reload_d;
         count_q  <= count_d;
      end
   end
`else
   assign tmr_fire = 1'b0;
`endif

   always_comb begin
      set_vec = '0;
      set_vec[N_SRC-1:0] = sync2_q & ~sync3_q;
`ifdef INTC_TIMER_EN
      set_vec[N_SRC] = tmr_fire;
`endif
   end

   // Lowest eligible index wins: scan downward so the last hit is the lowest.
   always_comb begin
      win_id = '0;
      for (int i = PW - 1; i >= 0; i--) begin
         if (elig[i]) win_id = ID_W'(i);
      end
   end

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < PW; i++) begin
         ack_clr[i] = (state_q == ST_REQ) && bus.ack && (irq_id_q == ID_W'(i));
      end
   end

   // New edges are applied last so a coincident set beats any clear.
   always_comb begin
      pend_d = pend_q & ~ack_clr;
      if (wr_pend) pend_d = pend_d & ~bus.reg_wdata[PW-1:0];
      pend_d = pend_d | set_vec;
      mask_d = wr_mask ? bus.reg_wdata[PW-1:0] : mask_q;
   end

   always_comb begin
      state_d   = state_q;
      irq_out_d = irq_out_q;
      irq_id_d  = irq_id_q;
      case (state_q)
         ST_IDLE: begin
            irq_out_d = 1'b0;
            if (elig != '0) begin
               irq_id_d  = win_id;
               irq_out_d = 1'b1;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            irq_out_d = 1'b1;
            if (bus.ack) begin
               irq_out_d = 1'b0;
               state_d   = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            irq_out_d = 1'b0;
            if (bus.eret) state_d = ST_IDLE;
         end
         default: begin
            irq_out_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         sync3_q   <= '0;
         pend_q    <= '0;
         mask_q    <= '0;
         state_q   <= ST_IDLE;
         irq_out_q <= 1'b0;
         irq_id_q  <= '0;
      end else begin
         sync1_q   <= irq_src;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         state_q   <= state_d;
         irq_out_q <= irq_out_d;
         irq_id_q  <= irq_id_d;
      end
   end

   always_comb begin
      bus.reg_rdata = '0;
      case (bus.reg_addr)
         2'd0: bus.reg_rdata[PW-1:0] = pend_q;
         2'd1: bus.reg_rdata[PW-1:0] = mask_q;
         2'd2: begin
            bus.reg_rdata[1:0]       = state_q;
            bus.reg_rdata[8 +: ID_W] = irq_id_q;
            bus.reg_rdata[16]        = (elig != '0);
         end
`ifdef INTC_TIMER_EN
         2'd3: bus.reg_rdata = count_q;
`endif
         default: bus.reg_rdata = '0;
      endcase
   end

   assign bus.irq_out = irq_out_q;
   assign bus.irq_id  = irq_id_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed per-cycle vector bench for intr_ctrl; each step drives one cycle then checks irq_out, irq_id and one register read.
module tb_intr_ctrl;
   localparam int N_SRC = 8;
   localparam int ID_W  = 4;

   logic             clk;
   logic             rst;
   logic [N_SRC-1:0] irq_src;

   intr_ctrl_if #(.ID_W(ID_W)) bus ();

   intr_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .irq_src (irq_src),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             rst;
      logic [N_SRC-1:0] src;
      logic             we;
      logic [1:0]       waddr;
      logic [31:0]      wdata;
      logic             ack;
      logic             eret;
      logic [1:0]       raddr;
      logic             exp_out;
      logic [ID_W-1:0]  exp_id;
      logic [31:0]      exp_rd;
   } vec_t;

   localparam logic [1:0] A_PEND = 2'd0, A_MASK = 2'd1, A_STAT = 2'd2, A_TMR = 2'd3;

   int   total = 0;
   int   bad   = 0;
   int   stepn = 0;
   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [N_SRC-1:0] s, logic w, logic [1:0] wa,
                               logic [31:0] wd, logic a, logic e, logic [1:0] ra,
                               logic eo, logic [ID_W-1:0] ei, logic [31:0] er);
      vec_t v;
      v.rst = r; v.src = s; v.we = w; v.waddr = wa; v.wdata = wd; v.ack = a; v.eret = e;
      v.raddr = ra; v.exp_out = eo; v.exp_id = ei; v.exp_rd = er;
      return v;
   endfunction

   task automatic step(input vec_t v);
      @(negedge clk);
      rst           = v.rst;
      irq_src       = v.src;
      bus.reg_we    = v.we;
      bus.reg_addr  = v.waddr;
      bus.reg_wdata = v.wdata;
      bus.ack       = v.ack;
      bus.eret      = v.eret;
      @(posedge clk);
      #1;
      bus.reg_we   = 1'b0;
      bus.ack      = 1'b0;
      bus.eret     = 1'b0;
      bus.reg_addr = v.raddr;
      #1;
      total++;
      if (bus.irq_out !== v.exp_out) begin
         bad++;
         $display("FAIL step %0d irq_out: got %b want %b", stepn, bus.irq_out, v.exp_out);
      end
      total++;
      if (bus.irq_id !== v.exp_id) begin
         bad++;
         $display("FAIL step %0d irq_id: got %0d want %0d", stepn, bus.irq_id, v.exp_id);
      end
      total++;
      if (bus.reg_rdata !== v.exp_rd) begin
         bad++;
         $display("FAIL step %0d rdata[addr %0d]: got 0x%08h want 0x%08h",
                  stepn, v.raddr, bus.reg_rdata, v.exp_rd);
      end
      stepn++;
   endtask

   initial begin
      rst           = 1'b1;
      irq_src       = '0;
      bus.reg_we    = 1'b0;
      bus.reg_addr  = 2'd0;
      bus.reg_wdata = '0;
      bus.ack       = 1'b0;
      bus.eret      = 1'b0;
      repeat (3) @(posedge clk);

      //                rst src    we wa      wdata  ack eret raddr  out id rdata
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 0, 0, 32'h0));
      tbl.push_back(mk(0, 8'h04, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 0, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 0, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 0, 32'h04));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 0, 0, 32'h0));
      tbl.push_back(mk(0, 8'h00, 1, A_MASK, 32'h04, 0, 0, A_MASK, 0, 0, 32'h04));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 1, 2, 32'h10201));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  1, 0, A_PEND, 0, 2, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 0, 2, 32'h202));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 1, A_STAT, 0, 2, 32'h200));
      // two sources in one cycle: lowest index first
      tbl.push_back(mk(0, 8'h00, 1, A_MASK, 32'hFF, 0, 0, A_MASK, 0, 2, 32'hFF));
      tbl.push_back(mk(0, 8'h22, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 2, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 2, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 2, 32'h22));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 1, 1, 32'h22));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  1, 0, A_PEND, 0, 1, 32'h20));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 1, A_STAT, 0, 1, 32'h10100));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 1, 5, 32'h10501));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  1, 0, A_PEND, 0, 5, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 1, A_STAT, 0, 5, 32'h500));
      // mask drop and stray eret while in REQ
      tbl.push_back(mk(0, 8'h08, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 5, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 5, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 5, 32'h08));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 1, 3, 32'h10301));
      tbl.push_back(mk(0, 8'h00, 1, A_MASK, 32'h0,  0, 0, A_STAT, 1, 3, 32'h301));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 1, A_STAT, 1, 3, 32'h301));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  1, 0, A_PEND, 0, 3, 32'h0));
      // edge on 4 coincident with W1C of bit 4: set wins
      tbl.push_back(mk(0, 8'h10, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 3, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 3, 32'h0));
      tbl.push_back(mk(0, 8'h00, 1, A_PEND, 32'h10, 0, 0, A_PEND, 0, 3, 32'h10));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 0, 3, 32'h302));
      // reset while in SERVICE, then no re-raise without a new edge
      tbl.push_back(mk(1, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 0, 0, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 0, 32'h0));
      tbl.push_back(mk(0, 8'h00, 1, A_MASK, 32'hFF, 0, 0, A_MASK, 0, 0, 32'hFF));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 0, 0, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_STAT, 0, 0, 32'h0));
      // plain W1C clears a pending bit
      tbl.push_back(mk(0, 8'h40, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 0, 32'h0));
      tbl.push_back(mk(0, 8'h00, 1, A_MASK, 32'h0,  0, 0, A_PEND, 0, 0, 32'h0));
      tbl.push_back(mk(0, 8'h00, 0, A_PEND, 32'h0,  0, 0, A_PEND, 0, 0, 32'h40));
      tbl.push_back(mk(0, 8'h00, 1, A_PEND, 32'h40, 0, 0, A_PEND, 0, 0, 32'h0));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

`ifdef INTC_TIMER_EN
      // timer: load 5 -> counts 4,3,2,1 -> fires and reloads -> REQ with id 8
      step(mk(0, 8'h00, 1, A_MASK, 32'h100, 0, 0, A_MASK, 0, 0, 32'h100));
      step(mk(0, 8'h00, 1, A_TMR,  32'h5,   0, 0, A_TMR,  0, 0, 32'h5));
      step(mk(0, 8'h00, 0, A_PEND, 32'h0,   0, 0, A_TMR,  0, 0, 32'h4));
      step(mk(0, 8'h00, 0, A_PEND, 32'h0,   0, 0, A_TMR,  0, 0, 32'h3));
      step(mk(0, 8'h00, 0, A_PEND, 32'h0,   0, 0, A_TMR,  0, 0, 32'h2));
      step(mk(0, 8'h00, 0, A_PEND, 32'h0,   0, 0, A_TMR,  0, 0, 32'h1));
      step(mk(0, 8'h00, 0, A_PEND, 32'h0,   0, 0, A_TMR,  0, 0, 32'h5));
      step(mk(0, 8'h00, 0, A_PEND, 32'h0,   0, 0, A_PEND, 1, 8, 32'h100));
      step(mk(0, 8'h00, 0, A_PEND, 32'h0,   1, 0, A_STAT, 0, 8, 32'h802));
`else
      step(mk(0, 8'h00, 1, A_TMR,  32'h5,   0, 0, A_TMR,  0, 0, 32'h0));
      step(mk(0, 8'h00, 0, A_PEND, 32'h0,   0, 0, A_PEND, 0, 0, 32'h0));
      step(mk(0, 8'h00, 0, A_PEND, 32'h0,   0, 0, A_STAT, 0, 0, 32'h0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
